key_event_arbiter: RTL and testbench

Collects one-cycle press flags from up to NUM_KEYS independent debounce filters, latches each as a pending event, and serialises them round-robin onto a single valid/ready event port carrying the key index. It sits between the per-key debounce filters and the single consumer of key events, such as the display or UART command sequencer. Events arriving for a key that still has one pending are counted as drops and are not queued.

---
 rtl/key_pkg.sv | 12 +
 rtl/rr_pick.sv | 36 +++
 rtl/key_event_arbiter.sv | 130 +++++++++++++
 tb/tb_key_event_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and sizing for the key event arbiter and its helpers.
package key_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam int unsigned DROP_CNT_W   = 8;
    localparam int unsigned NUM_KEYS_DEF = 4;

endpackage : key_pkg

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at N.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt_onehot,
    output logic [IDW-1:0] gnt_idx,
    output logic           any_req
);

    always_comb begin
        int unsigned j;
        logic [IDW-1:0] jj;
        logic found;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_req    = |req;
        found      = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            // ptr is always < N, so a single wrap subtraction suffices
            j = 32'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            jj = IDW'(j);
            if (!found && req[jj]) begin
                found          = 1'b1;
                gnt_onehot[jj] = 1'b1;
                gnt_idx        = jj;
            end
        end
    end

endmodule : rr_pick

// File: rtl/key_event_arbiter.sv
// Latches per-key press flags as pending events and serialises them round-robin
// onto a valid/ready port, counting events that collide with a still-pending one.
module key_event_arbiter
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS = NUM_KEYS_DEF,
    parameter int unsigned IDW      = $clog2(NUM_KEYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_KEYS-1:0]   key_flag,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [IDW-1:0]        evt_code,
    output logic [NUM_KEYS-1:0]   pend,
    output logic                  ovf,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    input  logic                  ovf_clr
);

    localparam int unsigned CNT_W = $clog2(NUM_KEYS + 1);
    localparam int unsigned SUM_W = DROP_CNT_W + 1;
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          rr_ptr, rr_d;
    logic                    valid_d;
    logic [IDW-1:0]          code_d;
    logic [NUM_KEYS-1:0]     pend_d;
    logic                    ovf_d;
    logic [DROP_CNT_W-1:0]   cnt_d;

    logic [NUM_KEYS-1:0]     pick_onehot;
    logic [IDW-1:0]          pick_idx;
    logic                    pick_any;
    logic                    load;
    logic [NUM_KEYS-1:0]     grant;
    logic [NUM_KEYS-1:0]     drops;
    logic [CNT_W-1:0]        ndrop;
    logic [SUM_W-1:0]        sum;

    rr_pick #(
        .N   (NUM_KEYS),
        .IDW (IDW)
    ) u_rr_pick (
        .req        (pend),
        .ptr        (rr_ptr),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any_req    (pick_any)
    );

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        valid_d = evt_valid;
        code_d  = evt_code;
        rr_d    = rr_ptr;
        grant   = '0;
        load    = 1'b0;
        ovf_d   = ovf;
        cnt_d   = drop_cnt;
        ndrop   = '0;

        case (state_q)
            IDLE: begin
                load = pick_any;
            end
            ISSUE: begin
                if (evt_ready) begin
                    if (pick_any) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (load) begin
            grant   = pick_onehot;
            code_d  = pick_idx;
            valid_d = 1'b1;
            state_d = ISSUE;
            rr_d    = (pick_idx == IDW'(NUM_KEYS - 1)) ? '0 : pick_idx + IDW'(1);
        end

        // A flag on a key being granted this cycle re-arms it rather than dropping
        pend_d = (pend & ~grant) | key_flag;
        drops  = key_flag & pend & ~grant;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            ndrop = ndrop + CNT_W'(drops[i]);
        end
        sum = {1'b0, drop_cnt} + SUM_W'(ndrop);

        if (ovf_clr) begin
            ovf_d = 1'b0;
            cnt_d = '0;
        end else if (|drops) begin
            ovf_d = 1'b1;
            cnt_d = (sum > SUM_W'(DROP_MAX)) ? DROP_MAX : sum[DROP_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            pend      <= '0;
            rr_ptr    <= '0;
            ovf       <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            state_q   <= state_d;
            evt_valid <= valid_d;
            evt_code  <= code_d;
            pend      <= pend_d;
            rr_ptr    <= rr_d;
            ovf       <= ovf_d;
            drop_cnt  <= cnt_d;
        end
    end

endmodule : key_event_arbiter

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter with hand-computed expectations.
module tb_key_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_flag;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_code;
    logic [3:0] pend;
    logic       ovf;
    logic [7:0] drop_cnt;
    logic       ovf_clr;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    key_event_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .key_flag  (key_flag),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .pend      (pend),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(evt_valid), 32'd0);
        check({tag, "_code"},  32'(evt_code),  32'd0);
        check({tag, "_pend"},  32'(pend),      32'd0);
        check({tag, "_ovf"},   32'(ovf),       32'd0);
        check({tag, "_drop"},  32'(drop_cnt),  32'd0);
    endtask

    initial begin
        rst = 1'b1; key_flag = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_all_zero("reset");

        // Simultaneous events from rr_ptr = 0: codes 0,1,2,3 back to back
        key_flag = 4'b1111; evt_ready = 1'b1;
        tick(); key_flag = '0;
        check("sim_pend", 32'(pend), 32'hf);
        check("sim_valid0", 32'(evt_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("sim_valid%0d", i), 32'(evt_valid), 32'd1);
            check($sformatf("sim_code%0d", i),  32'(evt_code),  32'(i));
        end
        check("sim_pend_end", 32'(pend), 32'd0);
        tick();
        check("sim_idle", 32'(evt_valid), 32'd0);

        // Fairness: keys 0 and 3 pulse every cycle; first grant 0 shows rr_ptr wrapped to 0
        key_flag = 4'b1001;
        tick();
        check("fair_wait", 32'(evt_valid), 32'd0);
        tick(); check("fair_c0", 32'(evt_code), 32'd0);
        tick(); check("fair_c1", 32'(evt_code), 32'd3);
        tick(); check("fair_c2", 32'(evt_code), 32'd0);
        key_flag = '0;
        tick(); check("fair_c3", 32'(evt_code), 32'd3);
        tick(); check("fair_c4", 32'(evt_code), 32'd0);
        check("fair_v4", 32'(evt_valid), 32'd1);
        tick(); check("fair_idle", 32'(evt_valid), 32'd0);
        check("fair_drop", 32'(drop_cnt), 32'd3);
        check("fair_ovf", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick(); ovf_clr = 1'b0;
        check("fair_clr_drop", 32'(drop_cnt), 32'd0);
        check("fair_clr_ovf", 32'(ovf), 32'd0);

        // Single event on key 2
        key_flag = 4'b0100;
        tick(); key_flag = '0;
        check("single_pend", 32'(pend), 32'h4);
        check("single_v0", 32'(evt_valid), 32'd0);
        tick();
        check("single_v1", 32'(evt_valid), 32'd1);
        check("single_code", 32'(evt_code), 32'd2);
        check("single_pend0", 32'(pend), 32'd0);
        tick();
        check("single_v2", 32'(evt_valid), 32'd0);

        // Backpressure on key 1 with three further pulses
        evt_ready = 1'b0; key_flag = 4'b0010;
        tick(); key_flag = '0;
        tick();
        check("bp_valid", 32'(evt_valid), 32'd1);
        check("bp_code", 32'(evt_code), 32'd1);
        key_flag = 4'b0010;
        tick();
        check("bp_pend1", 32'(pend), 32'h2);
        check("bp_drop0", 32'(drop_cnt), 32'd0);
        tick();
        check("bp_code_hold", 32'(evt_code), 32'd1);
        tick(); key_flag = '0;
        check("bp_valid_hold", 32'(evt_valid), 32'd1);
        check("bp_code_hold2", 32'(evt_code), 32'd1);
        check("bp_pend", 32'(pend), 32'h2);
        check("bp_drop", 32'(drop_cnt), 32'd2);
        check("bp_ovf", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick(); ovf_clr = 1'b0;
        check("bp_clr_drop", 32'(drop_cnt), 32'd0);
        check("bp_clr_ovf", 32'(ovf), 32'd0);
        evt_ready = 1'b1;
        tick();
        check("bp_next_valid", 32'(evt_valid), 32'd1);
        check("bp_next_code", 32'(evt_code), 32'd1);
        check("bp_next_pend", 32'(pend), 32'd0);
        tick();
        check("bp_idle", 32'(evt_valid), 32'd0);

        // Grant/flag collision on key 2
        key_flag = 4'b0100;
        tick();
        tick(); key_flag = '0;
        check("col_valid", 32'(evt_valid), 32'd1);
        check("col_code", 32'(evt_code), 32'd2);
        check("col_pend", 32'(pend), 32'h4);
        check("col_drop", 32'(drop_cnt), 32'd0);
        tick();
        check("col_valid2", 32'(evt_valid), 32'd1);
        check("col_code2", 32'(evt_code), 32'd2);
        check("col_pend2", 32'(pend), 32'd0);
        tick();
        check("col_idle", 32'(evt_valid), 32'd0);
        check("col_drop2", 32'(drop_cnt), 32'd0);
        check("col_ovf", 32'(ovf), 32'd0);

        // Reset mid-operation with an event presented and keys 1,3 pending
        evt_ready = 1'b0; key_flag = 4'b0001;
        tick(); key_flag = 4'b1010;
        tick(); key_flag = '0;
        check("rst_pre_valid", 32'(evt_valid), 32'd1);
        check("rst_pre_pend", 32'(pend), 32'ha);
        #2 rst = 1'b1;
        #1 check_all_zero("rst_async");
        tick();
        rst = 1'b0; evt_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rst_after%0d", i), 32'(evt_valid), 32'd0);
        end
        check("rst_after_pend", 32'(pend), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_key_event_arbiter
